// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, 1 or 2 stop bits.
// Optional parity (PARITY state and cfg_par decode) is built only when UART_TX_PARITY_EN is defined.
module uart_tx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 b_tick,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    input  logic [1:0]           cfg_par,
    input  logic                 cfg_stop2,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx
);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    state_t                 state_r;
    logic [TW-1:0]          tick_cnt_r;
    logic [BW-1:0]          bit_cnt_r;
    logic                   stop_cnt_r;
    logic                   stop2_r;
    logic [DATA_BITS-1:0]   data_buf_r;
    logic                   tick_end_s;

`ifdef UART_TX_PARITY_EN
    logic                   par_en_r;
    logic                   par_bit_r;

    // Parity over the word as accepted; odd=1 inverts the even result.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction
`else
    logic                   unused_cfg_par_s;
    assign unused_cfg_par_s = ^cfg_par;
`endif

    assign tick_end_s = b_tick && (tick_cnt_r == TICK_LAST);

    // Frame sequencer: state, bit/tick/stop counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= '0;
            bit_cnt_r  <= '0;
            stop_cnt_r <= 1'b0;
            stop2_r    <= 1'b0;
            data_buf_r <= '0;
`ifdef UART_TX_PARITY_EN
            par_en_r   <= 1'b0;
            par_bit_r  <= 1'b0;
`endif
            tx         <= 1'b1;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if ((state_r != ST_IDLE) && b_tick) begin
                tick_cnt_r <= tick_end_s ? '0 : tick_cnt_r + TW'(1);
            end
            case (state_r)
                ST_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        data_buf_r <= tx_data;
                        stop2_r    <= cfg_stop2;
`ifdef UART_TX_PARITY_EN
                        par_en_r   <= (cfg_par == 2'b01) || (cfg_par == 2'b10);
                        par_bit_r  <= parity_of(tx_data, cfg_par == 2'b10);
`endif
                        tick_cnt_r <= '0;
                        tx         <= 1'b0;
                        tx_busy    <= 1'b1;
                        tx_ready   <= 1'b0;
                        state_r    <= ST_START;
                    end else begin
                        tx       <= 1'b1;
                        tx_busy  <= 1'b0;
                        tx_ready <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick_end_s) begin
                        bit_cnt_r <= '0;
                        tx        <= data_buf_r[0];
                        state_r   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick_end_s) begin
                        if (bit_cnt_r == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            if (par_en_r) begin
                                tx      <= par_bit_r;
                                state_r <= ST_PARITY;
                            end else begin
                                tx         <= 1'b1;
                                stop_cnt_r <= 1'b0;
                                state_r    <= ST_STOP;
                            end
`else
                            tx         <= 1'b1;
                            stop_cnt_r <= 1'b0;
                            state_r    <= ST_STOP;
`endif
                        end else begin
                            bit_cnt_r  <= bit_cnt_r + BW'(1);
                            data_buf_r <= data_buf_r >> 1;
                            tx         <= data_buf_r[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (tick_end_s) begin
                        tx         <= 1'b1;
                        stop_cnt_r <= 1'b0;
                        state_r    <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick_end_s) begin
                        if (stop2_r && !stop_cnt_r) begin
                            stop_cnt_r <= 1'b1;
                        end else begin
                            tx_done  <= 1'b1;
                            tx_busy  <= 1'b0;
                            tx_ready <= 1'b1;
                            state_r  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    // Unreachable encodings fall back to a safe idle line.
                    tick_cnt_r <= '0;
                    tx         <= 1'b1;
                    tx_busy    <= 1'b0;
                    tx_ready   <= 1'b1;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: frame-level reference model with per-cycle compare, a mid-bit sampling RX monitor,
// and directed frames with hand-computed expectations.
module tb_uart_tx_cfg;
    localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       b_tick = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [1:0] cfg_par = 2'b00;
    logic       cfg_stop2 = 1'b0;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx;

    int n_chk = 0;
    int n_fail = 0;
    int n_done = 0;
    int cyc = 0;

    // model state
    bit         m_active = 1'b0;
    int         m_k = 0;
    int         m_n = 0;
    logic [11:0] m_bits = '1;
    logic       m_tx = 1'b1;
    logic       m_ready = 1'b1;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;

    // monitor state
    bit          mon_in = 1'b0;
    int          mon_t = 0;
    int          mon_done_cyc = 0;
    int          mon_gap = 0;
    logic [11:0] mon_samp = '1;
    logic [11:0] q_samp[$];
    int          q_len[$];
    int          q_gap[$];

    uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
        .clk(clk), .rst_n(rst_n), .b_tick(b_tick), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .cfg_par(cfg_par), .cfg_stop2(cfg_stop2), .tx_busy(tx_busy),
        .tx_done(tx_done), .tx(tx)
    );

    always #5 clk = ~clk;

    initial begin
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #1;
            div = (div == 3) ? 0 : div + 1;
            b_tick = (div == 3);
        end
    end

    // Expected line levels for one frame, index = bit period; returns number of bit periods.
    function automatic int build_frame(input logic [7:0] d, input logic [1:0] p, input logic s2,
                                       output logic [11:0] f);
        int n;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        n = 9;
        if (PAR_BUILT && (p == 2'b01 || p == 2'b10)) begin
            f[9] = (p == 2'b10) ? ~(^d) : (^d);
            n = 10;
        end
        return n + (s2 ? 2 : 1);
    endfunction

    // Reference model: a frame is a list of bit levels, each lasting OS b_ticks after the accept edge.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = 1'b0;
                m_k = 0;
                m_done = 1'b0;
            end else begin
                m_done = 1'b0;
                if (!m_active) begin
                    if (tx_valid === 1'b1) begin
                        m_active = 1'b1;
                        m_k = 0;
                        m_n = build_frame(tx_data, cfg_par, cfg_stop2, m_bits);
                    end
                end else if (b_tick === 1'b1) begin
                    m_k++;
                    if (m_k == OS * m_n) begin
                        m_active = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end
            m_tx    = m_active ? m_bits[m_k / OS] : 1'b1;
            m_busy  = m_active;
            m_ready = !m_active;
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            n_chk++;
            if (tx_done === 1'b1) n_done++;
            if (tx !== m_tx || tx_ready !== m_ready || tx_busy !== m_busy || tx_done !== m_done) begin
                n_fail++;
                $display("FAIL cycle_compare t=%0t tx/ready/busy/done got %b%b%b%b want %b%b%b%b",
                         $time, tx, tx_ready, tx_busy, tx_done, m_tx, m_ready, m_busy, m_done);
            end
        end
    end

    // Reference RX: detects the start bit, samples each bit at its middle tick, logs frame length in ticks.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                mon_in = 1'b0;
            end else begin
                if (!mon_in && tx === 1'b0) begin
                    mon_in = 1'b1;
                    mon_t = 0;
                    mon_samp = '1;
                    mon_gap = cyc - mon_done_cyc;
                end
                if (mon_in) begin
                    if (tx_done === 1'b1) begin
                        q_samp.push_back(mon_samp);
                        q_len.push_back(mon_t);
                        q_gap.push_back(mon_gap);
                        mon_done_cyc = cyc;
                        mon_in = 1'b0;
                    end else if (b_tick === 1'b1) begin
                        if ((mon_t % OS) == OS / 2 && (mon_t / OS) < 12) mon_samp[mon_t / OS] = tx;
                        mon_t++;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    task automatic send_word(input logic [7:0] d, input logic [1:0] p, input logic s2,
                             input bit keep, input bit align);
        bit acc;
        if (align) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 8 && b_tick !== 1'b1; i++) begin
                @(posedge clk);
                #2;
            end
        end
        tx_data = d;
        cfg_par = p;
        cfg_stop2 = s2;
        tx_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 3000 && !acc; i++) begin
            @(posedge clk);
            if (tx_ready === 1'b1) acc = 1'b1;
            #1;
        end
        chk("accept", int'(acc), 1);
        if (!keep) begin
            tx_valid = 1'b0;
            tx_data = ~d;
            cfg_par = ~p;
            cfg_stop2 = ~s2;
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clk);
            if (tx_done === 1'b1) seen = 1'b1;
        end
        chk("done_seen", int'(seen), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic pop_frame(input string name, input logic [7:0] want_word, input int want_len,
                             output logic [11:0] samp, output int gap);
        int len;
        samp = '1;
        gap = 0;
        if (q_len.size() == 0) begin
            chk({name, "_present"}, 0, 1);
        end else begin
            samp = q_samp.pop_front();
            len = q_len.pop_front();
            gap = q_gap.pop_front();
            chk({name, "_word"}, int'(samp[8:1]), int'(want_word));
            chk({name, "_len"}, len, want_len);
        end
    endtask

    initial begin
        logic [11:0] s;
        int g;
        int d0;
        int bad;

        // 1: reset and quiet idle line
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", int'(tx), 1);
        chk("rst_ready", int'(tx_ready), 1);
        chk("rst_busy", int'(tx_busy), 0);
        chk("rst_done", int'(tx_done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_ready !== 1'b1) bad++;
        end
        chk("idle_quiet", bad, 0);

        // 2: 8N1 0xA5, accept edge coincident with b_tick
        d0 = n_done;
        send_word(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1);
        wait_done();
        pop_frame("a5_8n1", 8'hA5, 160, s, g);
        chk("a5_pattern", int'(s[9:0]), 10'h34A);
        chk("a5_done_once", n_done - d0, 1);

        // 3: parity
`ifdef UART_TX_PARITY_EN
        send_word(8'hA5, 2'b01, 1'b0, 1'b0, 1'b0);
        wait_done();
        pop_frame("a5_even", 8'hA5, 176, s, g);
        chk("a5_even_bit", int'(s[9]), 0);
        chk("a5_even_stop", int'(s[10]), 1);
        send_word(8'hA5, 2'b10, 1'b0, 1'b0, 1'b0);
        wait_done();
        pop_frame("a5_odd", 8'hA5, 176, s, g);
        chk("a5_odd_bit", int'(s[9]), 1);
`else
        send_word(8'hA5, 2'b01, 1'b0, 1'b0, 1'b0);
        wait_done();
        pop_frame("a5_par_ignored", 8'hA5, 160, s, g);
        chk("a5_par_ignored_stop", int'(s[9]), 1);
`endif

        // 4: two stop bits
        send_word(8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
        wait_done();
        pop_frame("zero_2stop", 8'h00, 176, s, g);
        chk("zero_stop1", int'(s[9]), 1);
        chk("zero_stop2", int'(s[10]), 1);

        // 5: back-to-back with tx_valid held
        send_word(8'h55, 2'b00, 1'b0, 1'b1, 1'b0);
        send_word(8'hAA, 2'b00, 1'b0, 1'b0, 1'b0);
        wait_done();
        pop_frame("b2b_55", 8'h55, 160, s, g);
        pop_frame("b2b_aa", 8'hAA, 160, s, g);
        chk("b2b_gap", g, 1);

        // 6: reset during data bit 3, then a clean frame
        send_word(8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        repeat (290) @(posedge clk);
        #1;
        chk("mid_frame_tx_low", int'(tx), 0);
        rst_n = 1'b0;
        #1;
        chk("reset_tx_immediate", int'(tx), 1);
        chk("reset_busy_immediate", int'(tx_busy), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("no_partial_frame", q_len.size(), 0);
        send_word(8'h3C, 2'b00, 1'b0, 1'b0, 1'b0);
        wait_done();
        pop_frame("after_reset_3c", 8'h3C, 160, s, g);

        repeat (20) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
